// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Recovers HHMMSS decimal digits from the packed binary time value.
module bin_to_bcd_seq #(
    parameter int IN_WIDTH  = 24,
    parameter int DIGITS    = 8,
    parameter int CNT_WIDTH = $clog2(IN_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    generate
        if ((64'd10 ** DIGITS) <= (64'd1 << IN_WIDTH)) begin : g_digits_check
            $error("bin_to_bcd_seq: DIGITS too small for IN_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                      state;
    logic [IN_WIDTH-1:0]         shreg;
    logic [4*DIGITS-1:0]         scratch;
    logic [CNT_WIDTH-1:0]        cnt;
    logic [4*DIGITS-1:0]         adj;
    logic [4*DIGITS+IN_WIDTH-1:0] shifted;
    logic [4*DIGITS-1:0]         nxt_scratch;
    logic [IN_WIDTH-1:0]         nxt_shreg;

    // Each digit is corrected independently; no carry crosses digit boundaries.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_adj
            assign adj[4*k +: 4] = (scratch[4*k +: 4] >= 4'd5) ? scratch[4*k +: 4] + 4'd3
                                                              : scratch[4*k +: 4];
        end
    endgenerate

    assign shifted     = {adj, shreg} << 1;
    assign nxt_scratch = shifted[4*DIGITS+IN_WIDTH-1:IN_WIDTH];
    assign nxt_shreg   = shifted[IN_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= nxt_scratch;
                    shreg   <= nxt_shreg;
                    cnt     <= cnt + CNT_WIDTH'(1);
                    // Last shift: publish the result so done and bcd_out rise together.
                    if (cnt == CNT_WIDTH'(IN_WIDTH - 1)) begin
                        bcd_out <= nxt_scratch;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
